// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive-buffer geometry.
package uart_pkg;
    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_AFULL = 12;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset.
// Zero-latency read; no flow control of its own, the owner gates i_wr_en.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver; write-to-read latency 1 cycle.
// Consumer stalls with rd_ready=0; bytes arriving while full are dropped and flagged in sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = UART_FIFO_DEPTH,
    parameter int AFULL_LVL = UART_FIFO_AFULL
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_en,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic                     o_overrun,
    input  logic                     i_ovr_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LVL);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overrun;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;

    // Flags decode from the occupancy counter so a full queue is never mistaken for empty.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = !w_empty && i_rd_ready;
    assign w_push  = i_wr_en && (!w_full || w_pop);
    assign w_drop  = i_wr_en && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // A fresh drop must survive a clear issued in the same cycle.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    assign o_rd_data     = w_empty ? '0 : w_head;
    assign o_rd_valid    = !w_empty;
    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_almost_full = (r_count >= C_AFULL);
    assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random checks of uart_rx_fifo against a queue-based reference.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       almost_full;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_pop;
    bit         m_full;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_data     (wr_data),
        .i_wr_en       (wr_en),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .i_rd_ready    (rd_ready),
        .o_count       (count),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_overrun     (overrun),
        .i_ovr_clr     (ovr_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the queue holds exactly the bytes a consumer should still see.
    always @(posedge clk) begin
        if (rst_n) begin
            m_pop  = (mq.size() > 0) && rd_ready;
            m_full = (mq.size() == DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (wr_en && (!m_full || m_pop)) mq.push_back(wr_data);
            if (wr_en && m_full && !m_pop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ovr = 1'b0;
        end
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("rd_data", 32'(rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    end

    initial begin
        // Reset with write strobes toggling: none may land.
        for (int i = 0; i < 6; i++) begin
            wr_en   = i[0];
            wr_data = 8'(8'h30 + i);
            step();
        end
        chk("rst_count", 32'(count), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        wr_en = 1'b0;
        step();
        chk("post_rst_valid", 32'(rd_valid), 0);
        chk("post_rst_count", 32'(count), 0);

        // Single byte, one-cycle fall-through, then pop.
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("single_valid", 32'(rd_valid), 1);
        chk("single_data", 32'(rd_data), 32'hA5);
        chk("single_count", 32'(count), 1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("single_pop_valid", 32'(rd_valid), 0);
        chk("single_pop_count", 32'(count), 0);

        // Fill to the top, watching almost_full cross at 12.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
        end
        wr_en = 1'b0;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);

        // Overflow, clear, then clear racing a new overflow.
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        chk("ovf_set", 32'(overrun), 1);
        chk("ovf_count", 32'(count), 16);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovf_clr", 32'(overrun), 0);
        ovr_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        ovr_clr = 1'b0; wr_en = 1'b0;
        chk("ovf_set_wins", 32'(overrun), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        // Drain 8, refill across the pointer wrap.
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_lo", 32'(rd_data), 32'(i));
            step();
        end
        rd_ready = 1'b0;
        for (int i = 16; i < 24; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("refill_full", 32'(count), 16);

        // Full with simultaneous push and pop: write accepted, no overrun.
        chk("pp_head", 32'(rd_data), 32'h08);
        wr_en = 1'b1; wr_data = 8'h5A; rd_ready = 1'b1;
        step();
        wr_en = 1'b0;
        chk("pp_count", 32'(count), 16);
        chk("pp_overrun", 32'(overrun), 0);
        for (int i = 9; i < 24; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            step();
        end
        chk("drain_last", 32'(rd_data), 32'h5A);
        step();
        rd_ready = 1'b0;
        chk("drain_empty", 32'(rd_valid), 0);
        chk("drain_rd_data", 32'(rd_data), 0);

        // Random soak with shifting bias so both full and empty are exercised.
        for (int c = 0; c < 10000; c++) begin
            int wp;
            int rp;
            wp = ((c / 500) % 2 == 0) ? 75 : 35;
            rp = ((c / 500) % 2 == 0) ? 35 : 75;
            wr_en    = ($urandom_range(99) < wp);
            wr_data  = 8'($urandom);
            rd_ready = ($urandom_range(99) < rp);
            ovr_clr  = ($urandom_range(99) < 3);
            rst_n    = !(c >= 5000 && c < 5002);
            step();
        end
        wr_en = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0; rst_n = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
